// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//
// This block detects a configurable serial bit pattern in a stream. Each run
// covers a fixed number of accepted stream bits, called the window.
//
// Operation:
//   IDLE  -> a legal configuration is accepted -> ARMED
//   ARMED -> start -> RUN, or straight to DONE when the window is zero
//   RUN   -> accepts one bit per cycle while bit_valid is high; accepting
//            the final window bit moves to DONE
//   RUN   -> abort -> ARMED, with no done pulse
//   DONE  -> one cycle only, then ARMED
//
// Ports:
//   clock, reset_n       single clock; synchronous active-low reset
//   cfg_valid/cfg_ready  configuration handshake; accepted in IDLE and ARMED
//   cfg_pattern          pattern bits; bit 0 is the newest bit of the sequence
//   cfg_len              pattern length in bits, legal range 1..PAT_W
//   cfg_overlap          1 = a match may reuse bits from the previous match
//   cfg_window           number of accepted stream bits per run
//   cfg_err              one-cycle pulse after an illegal cfg_len is offered
//   start, abort         begin a run / end a run early
//   bit_valid, bit_in    serial stream input
//   busy, done           RUN state / one-cycle window-complete pulse
//   match                registered one-cycle pulse for each detected match
//   match_count          saturating count of matches in the current/last run
//   overflow             sticky flag; set when match_count saturated
// ---------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [WIN_W-1:0] cfg_window,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t state, state_next;

  // Stored configuration
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       len_q;
  logic             overlap_q;
  logic [WIN_W-1:0] window_q;

  // Run state
  logic [PAT_W-1:0] hist;
  logic [3:0]       fill;
  logic [WIN_W-1:0] win_cnt;
  logic             match_q;
  logic             cfg_err_q;

  // Decoded controls
  logic             cfg_fire, cfg_legal, start_fire, accept, last_bit, hit;
  logic [PAT_W-1:0] hist_shift, len_mask;
  logic [3:0]       fill_inc;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    cfg_fire   = cfg_valid && cfg_ready;
    cfg_legal  = (cfg_len != 4'd0) && (32'(cfg_len) <= PAT_W);
    // A configuration offered in the same cycle as start takes precedence,
    // whether or not that configuration is legal.
    start_fire = (state == ARMED) && start && !cfg_fire;
    // abort blocks acceptance of a bit, and therefore also blocks window
    // completion.
    accept     = (state == RUN) && bit_valid && !abort;
    last_bit   = accept && (win_cnt == WIN_W'(1));

    hist_shift = {hist[PAT_W-2:0], bit_in};
    // fill saturates at len_q, so "fill >= len" reduces to an equality test.
    fill_inc   = (fill < len_q) ? fill + 4'd1 : fill;
    len_mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = accept && (fill_inc == len_q) &&
          (((hist_shift ^ pat_q) & len_mask) == '0);

    state_next = state;
    unique case (state)
      IDLE:  if (cfg_fire && cfg_legal) state_next = ARMED;
      ARMED: if (start_fire) state_next = (window_q == '0) ? DONE : RUN;
      RUN: begin
        if (abort)         state_next = ARMED;
        else if (last_bit) state_next = DONE;
      end
      DONE:  state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples values from before this edge.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pat_q       <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      window_q    <= '0;
      hist        <= '0;
      fill        <= '0;
      win_cnt     <= '0;
      match_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      match_q   <= hit;
      cfg_err_q <= cfg_fire && !cfg_legal;

      if (cfg_fire && cfg_legal) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        window_q  <= cfg_window;
      end

      if (start_fire) begin
        match_count <= '0;
        overflow    <= 1'b0;
        hist        <= '0;
        fill        <= '0;
        win_cnt     <= window_q;
      end

      if (accept) begin
        hist    <= hist_shift;
        win_cnt <= win_cnt - WIN_W'(1);
        // In non-overlap mode, the next match must be built from len fresh
        // bits.
        fill    <= (hit && !overlap_q) ? 4'd0 : fill_inc;
        if (hit) begin
          if (&match_count) overflow    <= 1'b1;
          else              match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

  assign cfg_ready = (state == IDLE) || (state == ARMED);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign match     = match_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Directed testbench for seq_detect_ctrl. All expected values are computed
// by hand.
//
// Timing: inputs are driven 1 ns after a rising edge, and outputs are
// sampled at that same point. Each sample therefore shows the effect of the
// edge that has just passed.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             cfg_valid, cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [WIN_W-1:0] cfg_window;
  logic             cfg_err;
  logic             start, abort, bit_valid, bit_in;
  logic             busy, match, overflow, done;
  logic [CNT_W-1:0] match_count;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_window  (cfg_window),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic configure(input logic [PAT_W-1:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [WIN_W-1:0] win);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_window  = win;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Stream 0110110110. The first bit is at index 9.
  // Match masks use the same indexing: a match after bit k sits at index
  // 10-k.
  logic [9:0] stream      = 10'b0110110110;
  logic [9:0] exp_ovl     = 10'b0001001001;  // matches after bits 4, 7, 10
  logic [9:0] exp_non_ovl = 10'b0001000001;  // matches after bits 4, 10

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_window = '0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    tick();
    tick();
    check("rst cfg_ready", cfg_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst match", match, 0);
    check("rst count", match_count, 0);
    check("rst overflow", overflow, 0);
    check("rst cfg_err", cfg_err, 0);
    reset_n = 1'b1;

    // Illegal length 0 in IDLE: error pulse, state stays IDLE, start ignored
    configure(8'h06, 4'd0, 1'b1, 16'd10);
    check("len0 cfg_err", cfg_err, 1);
    tick();
    check("len0 cfg_err clears", cfg_err, 0);
    do_start();
    check("idle start busy", busy, 0);
    check("idle start done", done, 0);
    tick();
    check("idle start busy2", busy, 0);
    check("idle cfg_ready", cfg_ready, 1);

    // Overlapping detection of 0110
    configure(8'b0110, 4'd4, 1'b1, 16'd10);
    check("ovl cfg_err", cfg_err, 0);
    check("ovl armed ready", cfg_ready, 1);
    do_start();
    check("ovl busy", busy, 1);
    check("ovl ready in run", cfg_ready, 0);
    for (int i = 9; i >= 0; i--) begin
      feed(stream[i]);
      check($sformatf("ovl match bit%0d", 10 - i), match, exp_ovl[i]);
      if (i > 0) check($sformatf("ovl done bit%0d", 10 - i), done, 0);
    end
    check("ovl done", done, 1);
    check("ovl busy end", busy, 0);
    check("ovl count", match_count, 3);
    check("ovl ready in done", cfg_ready, 0);
    tick();
    check("ovl done 1 cycle", done, 0);
    check("ovl match clears", match, 0);
    check("ovl back armed", cfg_ready, 1);
    check("ovl count held", match_count, 3);

    // Non-overlapping detection of 0110
    configure(8'b0110, 4'd4, 1'b0, 16'd10);
    do_start();
    for (int i = 9; i >= 0; i--) begin
      feed(stream[i]);
      check($sformatf("non match bit%0d", 10 - i), match, exp_non_ovl[i]);
    end
    check("non done", done, 1);
    check("non count", match_count, 2);
    tick();

    // Illegal length 9 in ARMED: rejected, and the old configuration is kept
    configure(8'hFF, 4'd9, 1'b1, 16'd5);
    check("len9 cfg_err", cfg_err, 1);
    check("len9 stays armed", cfg_ready, 1);
    do_start();
    for (int i = 9; i >= 6; i--) feed(stream[i]);
    check("kept cfg match", match, 1);
    check("kept cfg count", match_count, 1);
    feed(1'b1);
    feed(1'b0);
    check("kept window busy", busy, 1);
    // Abort while a bit is offered: the bit is not accepted
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    check("abort busy", busy, 0);
    check("abort no done", done, 0);
    check("abort armed", cfg_ready, 1);
    check("abort count held", match_count, 1);

    // A configuration offered with start wins; start with window 0 then
    // goes straight to DONE
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_window = 16'd0;
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    check("cfg beats start busy", busy, 0);
    check("cfg beats start done", done, 0);
    do_start();
    check("win0 done", done, 1);
    check("win0 busy", busy, 0);
    check("win0 count cleared", match_count, 0);
    tick();
    check("win0 armed", cfg_ready, 1);

    // bit_valid toggling with window 4
    configure(8'h01, 4'd1, 1'b1, 16'd4);
    do_start();
    for (int k = 1; k <= 4; k++) begin
      feed(1'b1);
      check($sformatf("tog match v%0d", k), match, 1);
      check($sformatf("tog count v%0d", k), match_count, k);
      check($sformatf("tog done v%0d", k), done, (k == 4) ? 1 : 0);
      if (k < 4) begin
        bit_in = 1'b1;
        tick();
        check($sformatf("tog idle match %0d", k), match, 0);
        check($sformatf("tog idle busy %0d", k), busy, 1);
        check($sformatf("tog idle count %0d", k), match_count, k);
      end
    end
    tick();

    // Abort mid-run, then the next start clears the count
    do_start();
    feed(1'b1);
    feed(1'b1);
    check("mid count", match_count, 2);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    check("mid abort busy", busy, 0);
    check("mid abort done", done, 0);
    check("mid abort match", match, 0);
    check("mid abort count", match_count, 2);
    tick();
    check("mid abort no late done", done, 0);
    do_start();
    check("restart count cleared", match_count, 0);
    check("restart busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Saturation: 300 matching bits
    configure(8'h01, 4'd1, 1'b1, 16'd300);
    do_start();
    for (int k = 1; k <= 300; k++) begin
      feed(1'b1);
      if (k == 255) begin
        check("sat count 255", match_count, 255);
        check("sat no ovf 255", overflow, 0);
      end
      if (k == 256) begin
        check("sat count 256", match_count, 255);
        check("sat ovf 256", overflow, 1);
      end
      if (k == 299) check("sat done 299", done, 0);
    end
    check("sat done 300", done, 1);
    check("sat match 300", match, 1);
    check("sat count end", match_count, 255);
    check("sat ovf end", overflow, 1);
    tick();
    check("sat ovf held", overflow, 1);
    check("sat count held", match_count, 255);

    // Reset during RUN, with a matching bit offered on the reset edge
    configure(8'h01, 4'd1, 1'b1, 16'd10);
    do_start();
    feed(1'b1);
    feed(1'b1);
    reset_n = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("rrun busy", busy, 0);
    check("rrun match", match, 0);
    check("rrun count", match_count, 0);
    check("rrun overflow", overflow, 0);
    check("rrun done", done, 0);
    check("rrun cfg_err", cfg_err, 0);
    check("rrun cfg_ready", cfg_ready, 1);
    reset_n = 1'b1;
    do_start();
    check("rrun start ignored busy", busy, 0);
    check("rrun start ignored done", done, 0);
    tick();
    check("rrun still idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 8, max pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8, match counter width.
REQ-003 SHALL have parameter WIN_W, default 16, window counter width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 cfg_valid  in  1  configuration offer.
REQ-007 cfg_ready  out  1  configuration can be accepted.
REQ-008 cfg_pattern  in  PAT_W  pattern; bit 0 is last (newest) bit of sequence.
REQ-009 cfg_len  in  4  pattern length, legal 1..PAT_W.
REQ-010 cfg_overlap  in  1  1 = overlapping matches allowed.
REQ-011 cfg_window  in  WIN_W  number of accepted stream bits per run.
REQ-012 cfg_err  out  1  one-cycle pulse, illegal configuration rejected.
REQ-013 start  in  1  begin a run.
REQ-014 abort  in  1  terminate a run without done.
REQ-015 bit_valid  in  1  bit_in is valid this cycle.
REQ-016 bit_in  in  1  serial stream bit.
REQ-017 busy  out  1  high in RUN.
REQ-018 match  out  1  registered one-cycle pulse per detected match.
REQ-019 match_count  out  CNT_W  matches in current/last run.
REQ-020 overflow  out  1  sticky, match_count saturated.
REQ-021 done  out  1  one-cycle pulse, window completed.

Function
REQ-022 SHALL implement states IDLE, ARMED, RUN, DONE; done = (state==DONE), busy = (state==RUN).
REQ-023 cfg_ready SHALL be 1 in IDLE and ARMED, 0 in RUN and DONE.
REQ-024 On cfg_valid&&cfg_ready with cfg_len in 1..PAT_W: latch pattern, len, overlap, window; next state ARMED.
REQ-025 On cfg_valid&&cfg_ready with cfg_len 0 or >PAT_W: nothing latched, state unchanged, cfg_err=1 next cycle.
REQ-026 start SHALL be ignored in IDLE, RUN, DONE; config wins if cfg handshake and start coincide in ARMED (start ignored).
REQ-027 start in ARMED: clear match_count, overflow, history and history fill count; load window counter; next state RUN, or DONE if window = 0.
REQ-028 In RUN, bit accepted only when bit_valid=1: shift bit_in into history, increment fill count (saturating at len), decrement window counter; no change when bit_valid=0.
REQ-029 Match when the accepted bit completes fill count >= len and the newest len history bits (including bit_in) equal cfg_pattern[len-1:0].
REQ-030 On match: match=1 in following cycle; match_count increments, saturating at all-ones; increment attempted at all-ones sets overflow.
REQ-031 Non-overlap mode: on match, fill count cleared so next match needs len fresh bits; overlap mode: history retained.
REQ-032 Accepting the final window bit SHALL move to DONE; a match on that bit is counted and its match pulse coincides with done.
REQ-033 DONE lasts exactly one cycle, then ARMED; config retained, match_count and overflow held until next start.
REQ-034 abort in RUN: next state ARMED, no done, bit on same edge not accepted, match_count held; abort ignored elsewhere.
REQ-035 abort has priority over bit acceptance and window completion on the same edge.

Reset
REQ-036 reset_n=0 at a rising edge SHALL force IDLE, clear stored config, history, counters; outputs match, match_count, overflow, done, busy, cfg_err = 0, cfg_ready = 1 from next cycle, regardless of state.

Verification
REQ-037 cfg 0110b len 4 overlap 1 window 10, stream 0110110110 -> match after bits 4,7,10; match_count 3; done with final match.
REQ-038 same, overlap 0 -> match after bits 4,10; match_count 2.
REQ-039 cfg_len 0 in IDLE -> cfg_err pulse, state IDLE, start ignored, busy 0.
REQ-040 pattern 1b len 1 window 300, all ones -> match_count 255, overflow 1, done after bit 300.
REQ-041 bit_valid toggling every other cycle, window 4 -> only valid bits counted, done after 4th valid bit; abort mid-run -> ARMED, no done, next start clears count.
REQ-042 reset_n low during RUN with bit_valid=1 -> next cycle IDLE, all outputs reset values, start ignored until new config.
